// File: rtl/control_fsm.sv
// Multi-cycle control unit: FETCH -> EXEC (-> MEM) sequencing that drives every
// datapath strobe from the current state, the IR opcode and the ALU Z flag.
module control_fsm #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [7:0] Opcode,
    input  logic       Z,
    output logic [4:0] AluOp,
    output logic [1:0] Op2Sel,
    output logic       Op1Sel,
    output logic       Rw,
    output logic       WdSel,
    output logic       AluEn,
    output logic       SpEn,
    output logic       SpWe,
    output logic       LrEn,
    output logic       LrWe,
    output logic       PcWe,
    output logic [1:0] PcSel,
    output logic       PcEn,
    output logic       IrWe,
    output logic       ImmSel,
    output logic       RegWe,
    output logic       MemEn,
    output logic       Halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       run_q;
    logic [1:0] cls;
    logic [2:0] fn;
    logic       last_mem;
    logic       unused_opcode_lo;

    always_comb begin
        cls              = Opcode[7:6];
        fn               = Opcode[5:3];
        last_mem         = (wait_q == WAIT_LAST);
        unused_opcode_lo = ^Opcode[2:0];
    end

    // run_q stays low through the first edge after release, so the release
    // cycle carries no strobes and FETCH is held until the following cycle.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        AluOp   = '0;
        Op2Sel  = '0;
        Op1Sel  = 1'b0;
        Rw      = 1'b0;
        WdSel   = 1'b0;
        AluEn   = 1'b0;
        SpEn    = 1'b0;
        SpWe    = 1'b0;
        LrEn    = 1'b0;
        LrWe    = 1'b0;
        PcWe    = 1'b0;
        PcSel   = '0;
        PcEn    = 1'b0;
        IrWe    = 1'b0;
        ImmSel  = 1'b0;
        RegWe   = 1'b0;
        MemEn   = 1'b0;
        Halted  = 1'b0;

        if (nReset && run_q) begin
            unique case (state_q)
                S_FETCH: begin
                    PcEn    = 1'b1;
                    MemEn   = 1'b1;
                    IrWe    = 1'b1;
                    PcWe    = 1'b1;
                    PcSel   = 2'b00;
                    state_d = S_EXEC;
                end

                S_EXEC: begin
                    wait_d  = '0;
                    state_d = S_FETCH;
                    unique case (cls)
                        2'b00: begin
                            AluOp = {2'b00, fn};
                            AluEn = 1'b1;
                            RegWe = 1'b1;
                        end
                        2'b01: begin
                            AluOp  = {2'b01, fn};
                            Op2Sel = 2'b01;
                            ImmSel = 1'b1;
                            AluEn  = 1'b1;
                            RegWe  = 1'b1;
                        end
                        2'b10: begin
                            Op2Sel  = 2'b01;
                            ImmSel  = 1'b1;
                            AluEn   = 1'b1;
                            MemEn   = 1'b1;
                            Rw      = Opcode[3];
                            state_d = S_MEM;
                        end
                        2'b11: begin
                            // Only branch-class ops use the ALU target; RET drives LR onto SysBus.
                            if (!fn[2]) begin
                                Op1Sel = 1'b1;
                                Op2Sel = 2'b01;
                                AluEn  = 1'b1;
                                PcSel  = 2'b01;
                            end
                            unique case (fn)
                                3'b000: PcWe = 1'b1;
                                3'b001: PcWe = Z;
                                3'b010: PcWe = ~Z;
                                3'b011: begin
                                    LrWe = 1'b1;
                                    PcWe = 1'b1;
                                end
                                3'b100: begin
                                    LrEn  = 1'b1;
                                    PcWe  = 1'b1;
                                    PcSel = 2'b10;
                                end
                                3'b101: begin
                                    SpWe    = 1'b1;
                                    state_d = S_MEM;
                                end
                                3'b110: begin
                                    SpEn    = 1'b1;
                                    MemEn   = 1'b1;
                                    state_d = S_MEM;
                                end
                                3'b111: state_d = S_HALT;
                            endcase
                        end
                    endcase
                end

                S_MEM: begin
                    MemEn = 1'b1;
                    if (cls == 2'b10) begin
                        Op2Sel = 2'b01;
                        ImmSel = 1'b1;
                        AluEn  = 1'b1;
                        Rw     = Opcode[3];
                        if (last_mem && !Opcode[3]) begin
                            WdSel = 1'b1;
                            RegWe = 1'b1;
                        end
                    end else if (fn == 3'b101) begin
                        SpEn = 1'b1;
                        Rw   = 1'b1;
                    end else if (fn == 3'b110) begin
                        SpEn = 1'b1;
                        if (last_mem) begin
                            WdSel = 1'b1;
                            RegWe = 1'b1;
                            SpWe  = 1'b1;
                        end
                    end
                    if (last_mem) begin
                        state_d = S_FETCH;
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
                end

                S_HALT: Halted = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm (MEM_WAIT=2): an instruction-step model checked every
// cycle, plus directed literal expectations from the test plan.
module tb_control_fsm;

    localparam int MW = 2;

    logic       Clock, nReset, Z;
    logic [7:0] Opcode;
    logic [4:0] AluOp;
    logic [1:0] Op2Sel, PcSel;
    logic       Op1Sel, Rw, WdSel, AluEn, SpEn, SpWe, LrEn, LrWe, PcWe;
    logic       PcEn, IrWe, ImmSel, RegWe, MemEn, Halted;

    typedef struct packed {
        logic [4:0] alu_op;
        logic [1:0] op2_sel;
        logic       op1_sel, rw, wd_sel, alu_en, sp_en, sp_we, lr_en, lr_we, pc_we;
        logic [1:0] pc_sel;
        logic       pc_en, ir_we, imm_sel, reg_we, mem_en, halted;
    } ctl_t;

    ctl_t dut_v;
    assign dut_v = {AluOp, Op2Sel, Op1Sel, Rw, WdSel, AluEn, SpEn, SpWe, LrEn, LrWe,
                    PcWe, PcSel, PcEn, IrWe, ImmSel, RegWe, MemEn, Halted};

    control_fsm #(.MEM_WAIT(MW)) dut (
        .Clock(Clock), .nReset(nReset), .Opcode(Opcode), .Z(Z),
        .AluOp(AluOp), .Op2Sel(Op2Sel), .Op1Sel(Op1Sel), .Rw(Rw), .WdSel(WdSel),
        .AluEn(AluEn), .SpEn(SpEn), .SpWe(SpWe), .LrEn(LrEn), .LrWe(LrWe),
        .PcWe(PcWe), .PcSel(PcSel), .PcEn(PcEn), .IrWe(IrWe), .ImmSel(ImmSel),
        .RegWe(RegWe), .MemEn(MemEn), .Halted(Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction length in cycles: FETCH + EXEC, plus MW+1 MEM cycles for memory/stack ops.
    function automatic int ilen(input logic [7:0] op);
        if (op[7:6] == 2'b10 || op[7:3] == 5'b11101 || op[7:3] == 5'b11110)
            return 3 + MW;
        return 2;
    endfunction

    bit m_run  = 1'b0;
    bit m_halt = 1'b0;
    int m_step = 0;

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            m_run  = 1'b0;
            m_halt = 1'b0;
            m_step = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (!m_halt) begin
            if (m_step == 1 && Opcode[7:3] == 5'b11111) m_halt = 1'b1;
            else m_step = (m_step + 1) % ilen(Opcode);
        end
    end

    function automatic ctl_t model_out(input logic [7:0] op, input logic z, input bit run,
                                       input bit hlt, input int step);
        ctl_t c;
        logic [2:0] f;
        bit mem, last;
        c = '0;
        f = op[5:3];
        if (!run) return c;
        if (hlt) begin
            c.halted = 1'b1;
            return c;
        end
        if (step == 0) begin
            c.pc_en = 1'b1; c.mem_en = 1'b1; c.ir_we = 1'b1; c.pc_we = 1'b1;
            return c;
        end
        mem  = (step >= 2);
        last = (step == ilen(op) - 1);
        case (op[7:6])
            2'b00: begin
                c.alu_op = {2'b00, f}; c.alu_en = 1'b1; c.reg_we = 1'b1;
            end
            2'b01: begin
                c.alu_op = {2'b01, f}; c.op2_sel = 2'b01; c.imm_sel = 1'b1;
                c.alu_en = 1'b1; c.reg_we = 1'b1;
            end
            2'b10: begin
                c.op2_sel = 2'b01; c.imm_sel = 1'b1; c.alu_en = 1'b1;
                c.mem_en = 1'b1; c.rw = op[3];
                if (!op[3] && mem && last) begin
                    c.wd_sel = 1'b1; c.reg_we = 1'b1;
                end
            end
            default: begin
                case (f)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        c.op1_sel = 1'b1; c.op2_sel = 2'b01; c.alu_en = 1'b1; c.pc_sel = 2'b01;
                        c.pc_we = (f == 3'd1) ? z : (f == 3'd2) ? !z : 1'b1;
                        c.lr_we = (f == 3'd3);
                    end
                    3'd4: begin
                        c.lr_en = 1'b1; c.pc_we = 1'b1; c.pc_sel = 2'b10;
                    end
                    3'd5: begin
                        if (!mem) c.sp_we = 1'b1;
                        else begin
                            c.sp_en = 1'b1; c.mem_en = 1'b1; c.rw = 1'b1;
                        end
                    end
                    3'd6: begin
                        c.sp_en = 1'b1; c.mem_en = 1'b1;
                        if (mem && last) begin
                            c.wd_sel = 1'b1; c.reg_we = 1'b1; c.sp_we = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
        return c;
    endfunction

    always @(negedge Clock) begin
        if (cmp_en)
            check("cycle", 32'(dut_v), 32'(model_out(Opcode, Z, m_run, m_halt, m_step)));
    end

    // Waits for the next FETCH, loads the opcode, and returns one cycle into EXEC.
    task automatic start(input logic [7:0] op, input logic z);
        int unsigned n = 0;
        while (!(m_run && !m_halt && m_step == 0)) begin
            if (n == 30) begin
                n_vec++;
                n_err++;
                $display("FAIL start_timeout: got no FETCH expected FETCH within 30 cycles for op %h", op);
                return;
            end
            @(posedge Clock); #2;
            n++;
        end
        Opcode = op;
        Z      = z;
        @(posedge Clock); #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got no finish expected finish by 20000");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset = 1'b0;
        Opcode = 8'h00;
        Z      = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge Clock);
        #1 check("reset_outputs", 32'(dut_v), 32'h0);
        @(negedge Clock);
        nReset = 1'b1;
        #1 check("release_cycle", 32'(dut_v), 32'h0);
        @(posedge Clock); #2;
        check("fetch_PcEn", PcEn, 1);
        check("fetch_IrWe", IrWe, 1);
        check("fetch_PcWe", PcWe, 1);
        check("fetch_MemEn", MemEn, 1);
        check("fetch_PcSel", PcSel, 0);

        start(8'b00_011_000, 1'b0);
        check("alur_AluOp", AluOp, 5'b00011);
        check("alur_Op2Sel", Op2Sel, 0);
        check("alur_AluEn", AluEn, 1);
        check("alur_RegWe", RegWe, 1);
        @(posedge Clock); #2;
        check("alur_next_fetch", IrWe, 1);

        start(8'b01_101_000, 1'b0);
        check("alui_AluOp", AluOp, 5'b01101);

        start(8'b11_001_000, 1'b1);
        check("bz_z1_PcWe", PcWe, 1);
        check("bz_z1_PcSel", PcSel, 2'b01);
        start(8'b11_001_000, 1'b0);
        check("bz_z0_PcWe", PcWe, 0);
        start(8'b11_010_000, 1'b1);
        check("bnz_z1_PcWe", PcWe, 0);
        start(8'b11_010_000, 1'b0);
        check("bnz_z0_PcWe", PcWe, 1);
        start(8'b11_000_000, 1'b0);

        start(8'b10_000_000, 1'b0);
        check("ldw_exec_MemEn", MemEn, 1);
        check("ldw_exec_RegWe", RegWe, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock); #2;
            check("ldw_mem_MemEn", MemEn, 1);
            check("ldw_mem_RegWe", RegWe, (k == 2) ? 1 : 0);
            check("ldw_mem_WdSel", WdSel, (k == 2) ? 1 : 0);
        end
        @(posedge Clock); #2;
        check("ldw_next_fetch", IrWe, 1);

        start(8'b10_001_000, 1'b0);
        check("stw_exec_Rw", Rw, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock); #2;
            check("stw_mem_Rw", Rw, 1);
            check("stw_mem_RegWe", RegWe, 0);
        end

        start(8'b11_011_000, 1'b0);
        check("bl_LrWe", LrWe, 1);
        check("bl_PcWe", PcWe, 1);
        start(8'b11_100_000, 1'b0);
        check("ret_LrEn", LrEn, 1);
        check("ret_PcSel", PcSel, 2'b10);
        check("ret_PcWe", PcWe, 1);

        start(8'b11_110_000, 1'b0);
        check("pop_exec_SpEn", SpEn, 1);

        start(8'b11_101_000, 1'b0);
        check("push_exec_SpWe", SpWe, 1);
        @(posedge Clock); #2;
        check("push_mem_SpEn", SpEn, 1);
        check("push_mem_Rw", Rw, 1);
        nReset = 1'b0;
        #1 check("push_abort_outputs", 32'(dut_v), 32'h0);
        check("push_abort_SpWe", SpWe, 0);
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        #1 check("push_release_cycle", 32'(dut_v), 32'h0);
        @(posedge Clock); #2;
        check("push_restart_PcEn", PcEn, 1);
        check("push_restart_IrWe", IrWe, 1);

        start(8'b11_111_000, 1'b0);
        check("halt_exec_outputs", 32'(dut_v), 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge Clock); #2;
            check("halt_outputs", 32'(dut_v), 32'h1);
        end
        nReset = 1'b0;
        #1 check("halt_reset_Halted", Halted, 0);
        @(negedge Clock);
        nReset = 1'b1;
        @(posedge Clock); #2;
        check("halt_exit_fetch", PcEn, 1);

        @(negedge Clock);
        #1 cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle control unit for the 16-bit processor. It sits directly upstream of the datapath.
- It consumes the datapath's Opcode and Z flag and drives every datapath control strobe: ALU, register file, PC, LR, SP, IR and memory.
- One instruction executes per FETCH→EXEC(→MEM) sequence.

Parameters:
- MEM_WAIT, default 0: number of extra wait cycles spent in MEM before its final cycle. Range 0..7.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous active-low reset.
- Opcode  in  8  instruction opcode from the datapath IR; valid from EXEC onward.
- Z  in  1  ALU zero flag from the datapath.
- AluOp  out  5  ALU function select.
- Op2Sel  out  2  ALU operand 2 select: 00=Rb, 01=immediate, 10=constant 1.
- Op1Sel  out  1  ALU operand 1 select: 0=Ra, 1=PC.
- Rw  out  1  memory direction: 1=write, 0=read.
- WdSel  out  1  register write-data select: 0=ALU, 1=DataIn.
- AluEn  out  1  drive ALU result onto SysBus.
- SpEn  out  1  drive SP onto the address bus.
- SpWe  out  1  SP update strobe.
- LrEn  out  1  drive LR onto SysBus.
- LrWe  out  1  LR load strobe (LR←PC).
- PcWe  out  1  PC load strobe.
- PcSel  out  2  PC next-value select: 00=PC+1, 01=SysBus (ALU target), 10=LR.
- PcEn  out  1  drive PC onto the address bus.
- IrWe  out  1  IR load strobe.
- ImmSel  out  1  immediate format: 0=sign-extended 8-bit, 1=sign-extended 5-bit.
- RegWe  out  1  register file write strobe.
- MemEn  out  1  memory access enable.
- Halted  out  1  high while in HALT.

Behaviour:
- States: FETCH, EXEC, MEM, HALT. Asynchronous reset forces FETCH.
- While nReset=0, all outputs are 0, including Halted.
- Outputs are combinational from the state and Opcode. Every output not listed for a state/opcode is 0.
- FETCH (1 cycle): PcEn=1, MemEn=1, IrWe=1, PcWe=1, PcSel=00. Next state is EXEC.
- Decode fields: C=Opcode[7:6], F=Opcode[5:3].
- EXEC, C=00 (ALU register op): AluOp={2'b00,F}, Op2Sel=00, AluEn=1, RegWe=1, WdSel=0. Next state is FETCH.
- EXEC, C=01 (ALU immediate op): as C=00 but with Op2Sel=01, ImmSel=1, AluOp={2'b01,F}. Next state is FETCH.
- EXEC, C=10 (memory op):
  - Address computation: AluOp=5'b00000 (add), Op2Sel=01, ImmSel=1, AluEn=1, MemEn=1.
  - Rw=Opcode[3]: 1=STW, 0=LDW.
  - Next state is MEM.
- EXEC, C=11 (control op): Op1Sel=1, Op2Sel=01, ImmSel=0, AluOp=5'b00000, AluEn=1, as needed by each F:
  - F=000 BR: PcWe=1, PcSel=01.
  - F=001 BZ: PcWe=Z, PcSel=01.
  - F=010 BNZ: PcWe=!Z, PcSel=01.
  - F=011 BL: LrWe=1 and PcWe=1 in the same cycle; LR captures the pre-update PC (already PC+1), PcSel=01.
  - F=100 RET: LrEn=1, PcWe=1, PcSel=10.
  - F=101 PUSH: SpWe=1 (SP−1). Next state is MEM.
  - F=110 POP: SpEn=1, MemEn=1. Next state is MEM.
  - F=111 HALT: next state is HALT.
  - All other C=11 ops return to FETCH.
- MEM holds for MEM_WAIT+1 cycles, counted by an internal 3-bit wait counter.
  - The counter is cleared on entry to MEM and on reset.
  - MemEn and the address source are held on every MEM cycle.
  - Final-cycle strobes fire only on the last MEM cycle:
    - LDW: WdSel=1, RegWe=1, MemEn=1.
    - STW: Rw=1, MemEn=1.
    - PUSH: SpEn=1, MemEn=1, Rw=1.
    - POP: WdSel=1, RegWe=1, SpWe=1 (SP+1).
  - Rw for STW/PUSH stays asserted on every MEM cycle.
  - After the last cycle, next state is FETCH.
- HALT: Halted=1, all strobes 0. Only reset exits HALT.
- Strobe timing: at most one PcWe and one RegWe per instruction. No strobe is asserted in the same cycle as reset release.
- Reset mid-instruction abandons the instruction and restarts at FETCH once nReset rises.

Test Plan:
- Reset: hold nReset=0 for 3 cycles, release → all outputs 0 during reset; first cycle after release is FETCH with PcEn=IrWe=PcWe=MemEn=1, PcSel=00.
- ALU reg: Opcode=8'b00_011_000 → EXEC asserts AluOp=5'b00011, Op2Sel=00, AluEn=1, RegWe=1; next cycle is FETCH (2-cycle instruction).
- Branch: Opcode=8'b11_001_000 with Z=1 → PcWe=1, PcSel=01; repeated with Z=0 → PcWe=0. BNZ (8'b11_010_000) gives the inverse results.
- Memory, MEM_WAIT=2: LDW (8'b10_000_000) → EXEC, then 3 MEM cycles with MemEn=1, RegWe=1 and WdSel=1 only on the 3rd; STW (8'b10_001_000) → Rw=1 throughout MEM, RegWe never 1.
- BL then RET: BL (8'b11_011_000) → LrWe=1 and PcWe=1 in the same EXEC cycle; RET (8'b11_100_000) → LrEn=1, PcSel=10, PcWe=1.
- HALT/reset mid-op: Opcode=8'b11_111_000 → Halted=1 indefinitely, all strobes 0; assert nReset low during the MEM state of a PUSH → outputs 0 immediately (asynchronously), restart in FETCH, no SP write.
